// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the count sequence checker.
//   chk_state_e       : checker FSM state (unlocked / acquiring / locked)
//   ResyncLenDefault  : default number of consecutive good increments needed to lock
package count_chk_pkg;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAcquire  = 2'd1,
    StLocked   = 2'd2
  } chk_state_e;

  localparam int unsigned ResyncLenDefault = 3;

endpackage

// File: rtl/count_chk_sat_cnt.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, q -> 0
//   inc : increment by one, sticking at all-ones
//   clr : synchronous clear, q -> 0 (wins over inc)
//   q   : current count
module count_chk_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running counter stream. Each accepted sample
// (in_valid && enable) is compared with the previous accepted sample + 1 (mod 2^WIDTH).
// Lock is declared after RESYNC_LEN consecutive good increments; a break while locked
// pulses mismatch, bumps a saturating error count and drops back to acquisition.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : in_count carries a sample this cycle
//   in_count   : observed counter value
//   enable     : checker active; when low, samples are ignored and state holds
//   clear      : synchronous clear of err_count (and wrap_count)
//   locked     : high while in the locked state
//   mismatch   : one-cycle pulse per error detected while locked
//   expected   : next expected counter value
//   err_count  : saturating count of locked mismatches
//   wrap_count : saturating count of locked wraps to zero
// Optional feature: define COUNT_SEQ_CHECKER_WRAP_STATS_EN to add wrap_count.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned RESYNC_LEN = ResyncLenDefault,
  parameter int unsigned ERR_CNT_W  = 8
`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
  ,
  parameter int unsigned WRAP_CNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 enable,
  input  logic                 clear,
  output logic                 locked,
  output logic                 mismatch,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

  // Wide enough to hold RESYNC_LEN itself.
  localparam int unsigned GoodRunW = $clog2(RESYNC_LEN + 1);

  chk_state_e          state;
  logic [GoodRunW-1:0] good_run;

  logic             accept;
  logic             match;
  logic [WIDTH-1:0] next_exp;
  logic             err_inc;

  assign accept   = in_valid && enable;
  assign match    = (in_count == expected);
  assign next_exp = in_count + WIDTH'(1);
  assign err_inc  = accept && (state == StLocked) && !match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StUnlocked;
      good_run <= '0;
      expected <= '0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (accept) begin
        // Every accepted sample re-seeds the expectation, matching or not.
        expected <= next_exp;
        unique case (state)
          StUnlocked: begin
            good_run <= '0;
            state    <= StAcquire;
          end
          StAcquire: begin
            if (match) begin
              good_run <= good_run + GoodRunW'(1);
              if ((32'(good_run) + 32'd1) == RESYNC_LEN) begin
                state  <= StLocked;
                locked <= 1'b1;
              end
            end else begin
              // Errors during acquisition only restart the run; they are not reported.
              good_run <= '0;
            end
          end
          StLocked: begin
            if (!match) begin
              mismatch <= 1'b1;
              good_run <= '0;
              state    <= StAcquire;
              locked   <= 1'b0;
            end
          end
          default: begin
            state    <= StUnlocked;
            good_run <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  count_chk_sat_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clear),
    .q   (err_count)
  );

`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
  logic wrap_inc;

  assign wrap_inc = accept && (state == StLocked) && match && (in_count == '0);

  count_chk_sat_cnt #(
    .W (WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_inc),
    .clr (clear),
    .q   (wrap_count)
  );
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker. The driver computes the expected outputs
// from a history of accepted samples (locked <=> the last RESYNC_LEN steps were all +1)
// and queues them; a monitor pops one entry per clock and compares.
module tb_count_seq_checker;

  localparam int RL = 3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_count;
  logic       enable;
  logic       clear;
  logic       locked;
  logic       mismatch;
  logic [3:0] expected;
  logic [7:0] err_count;
`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
  logic [7:0] wrap_count;
`endif

  count_seq_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .enable    (enable),
    .clear     (clear),
    .locked    (locked),
    .mismatch  (mismatch),
    .expected  (expected),
    .err_count (err_count)
`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       locked;
    logic       mismatch;
    logic [3:0] expected;
    logic [7:0] err;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int hist[$];
  int m_err  = 0;
  int m_wrap = 0;

  function automatic bit model_locked();
    int n;
    n = hist.size();
    if (n < RL + 1) return 1'b0;
    for (int i = n - RL; i < n; i++) begin
      if (hist[i] != ((hist[i-1] + 1) % 16)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("locked", int'(locked), int'(mon_e.locked));
      chk("mismatch", int'(mismatch), int'(mon_e.mismatch));
      chk("expected", int'(expected), int'(mon_e.expected));
      chk("err_count", int'(err_count), int'(mon_e.err));
`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
      chk("wrap_count", int'(wrap_count), int'(mon_e.wrap));
`endif
    end
  end

  task automatic drive(input bit r, input bit v, input bit e, input bit c, input int cnt);
    exp_t x;
    bit   pl;
    bit   mt;
    int   val;
    val = cnt & 15;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    enable   = e;
    clear    = c;
    in_count = 4'(val);
    x.mismatch = 1'b0;
    if (r) begin
      hist.delete();
      m_err  = 0;
      m_wrap = 0;
    end else begin
      pl = model_locked();
      if (v && e) begin
        if (hist.size() > 0) begin
          mt = (val == ((hist[$] + 1) % 16));
          if (pl && !mt) begin
            x.mismatch = 1'b1;
            if (m_err < 255) m_err++;
          end
          if (pl && mt && val == 0 && m_wrap < 255) m_wrap++;
        end
        hist.push_back(val);
        if (hist.size() > RL + 1) void'(hist.pop_front());
      end
      if (c) begin
        m_err  = 0;
        m_wrap = 0;
      end
    end
    x.locked   = model_locked();
    x.expected = (hist.size() > 0) ? 4'((hist[$] + 1) % 16) : 4'd0;
    x.err      = 8'(m_err);
    x.wrap     = 8'(m_wrap);
    sb.push_back(x);
  endtask

  task automatic feed(input int cnt);
    drive(1'b0, 1'b1, 1'b1, 1'b0, cnt);
  endtask

  int cur;
  int base;
  int val;
  bit rv, rev, rc, rr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; enable = 1'b0; clear = 1'b0; in_count = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 9);

    // Acquire and lock on 5..8, then run through the 15 -> 0 wrap.
    for (int i = 5; i <= 8; i++) feed(i);
    for (int i = 9; i <= 19; i++) feed(i);
    // Expected is 4: a counter reset to 0 is a mismatch, then relock on 1,2,3.
    feed(0);
    feed(1); feed(2); feed(3);
    cur = 4;

    // Repeated locked breaks drive err_count to saturation.
    for (int i = 0; i < 256; i++) begin
      base = cur + 7;
      feed(base);
      feed(base + 1); feed(base + 2); feed(base + 3);
      cur = base + 4;
    end
    // Clear coinciding with a locked mismatch.
    base = cur + 5;
    drive(1'b0, 1'b1, 1'b1, 1'b1, base);
    // Two good samples during acquisition, then an out-of-sequence value.
    feed(base + 1); feed(base + 2);
    feed(base + 9);
    feed(base + 10); feed(base + 11); feed(base + 12);
    cur = base + 13;

    // enable low: everything holds.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                                      int'($urandom_range(0, 15)));

    // Build err_count = 7 while locked, then reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    feed(0); feed(1); feed(2); feed(3);
    cur = 4;
    for (int i = 0; i < 7; i++) begin
      base = cur + 3;
      feed(base);
      feed(base + 1); feed(base + 2); feed(base + 3);
      cur = base + 4;
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, cur);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Randomized stream with glitches, stalls, resets, gaps and clears.
    cur = int'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 9) != 0);
      rev = ($urandom_range(0, 19) != 0);
      rc  = ($urandom_range(0, 49) == 0);
      rr  = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 99)) inside
        [0:5]:   val = int'($urandom_range(0, 15));
        [6:8]:   val = 0;
        [9:10]:  val = cur + 15;
        default: val = cur;
      endcase
      drive(rr, rv, rev, rc, val);
      if (rv && rev) cur = (val + 1) & 15;
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side checker for the 4-bit synchronous free-running counter stream: samples a count value each valid cycle and verifies that it advances by +1 modulo 2^WIDTH.
- Acquires lock after a run of consecutive good samples, flags discontinuities including counter resets and skips, and keeps a saturating error tally.
- Sits beside the counter as an in-design monitor; outputs feed status registers and the verification scoreboard.

Parameters:
WIDTH, 4, width of observed count
RESYNC_LEN, 3, consecutive correct increments required to declare lock (>=1)
ERR_CNT_W, 8, width of saturating error counter
WRAP_CNT_W, 8, width of saturating wrap counter (optional feature only)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  in_count is a sample this cycle
in_count  input  WIDTH  observed counter value
enable  input  1  checker active; when low, samples are ignored and all state is held
clear  input  1  synchronous clear of err_count (and wrap_count)
locked  output  1  registered; high while in LOCKED
mismatch  output  1  registered one-cycle pulse per detected error
expected  output  WIDTH  registered next expected value
err_count  output  ERR_CNT_W  saturating count of mismatches seen while locked
wrap_count  output  WRAP_CNT_W  present only with the optional feature

Behaviour:
- Reset: state=UNLOCKED, locked=0, mismatch=0, expected=0, err_count=0, good_run=0, wrap_count=0.
- A sample is accepted when in_valid && enable. All outputs update on the clock edge after acceptance (latency 1). With no accepted sample, mismatch=0 and all other state holds.
- Match rule: in_count == expected, where expected = previous accepted in_count + 1, truncated to WIDTH bits (15 -> 0 is a match for WIDTH=4).
- FSM states: UNLOCKED, ACQUIRE, LOCKED.
- UNLOCKED, on accept: expected <= in_count+1; good_run <= 0; go to ACQUIRE. No comparison is made.
- ACQUIRE, on accept with match: good_run++, expected <= in_count+1. If good_run+1 == RESYNC_LEN, go to LOCKED and set locked=1.
- ACQUIRE, on accept with mismatch: good_run <= 0, expected <= in_count+1, stay in ACQUIRE. No mismatch pulse and no error count.
- LOCKED, on accept with match: expected <= in_count+1; stay locked.
- LOCKED, on accept with mismatch: mismatch=1 for one cycle; err_count++, saturating at all-ones; expected <= in_count+1; good_run <= 0; go to ACQUIRE; locked=0.
- A counter reset (in_count=0 when expected!=0) is an ordinary mismatch. A repeated value (stall) is also a mismatch.
- clear: err_count (and wrap_count) go to 0 next cycle. FSM, expected, and mismatch are unaffected. If clear coincides with a mismatch increment, clear wins (result 0) but the mismatch pulse still fires.
- rst mid-operation overrides everything and returns to the reset values in one cycle.
- enable deasserting mid-acquire freezes good_run and state; there is no timeout.

Optional Feature:
- Macro COUNT_SEQ_CHECKER_WRAP_STATS_EN.
- Defined: adds the wrap_count port. In LOCKED, a matching sample with in_count==0 increments wrap_count, saturating. Cleared by rst and by clear.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package count_chk_pkg: state enum typedef (UNLOCKED/ACQUIRE/LOCKED, 2-bit) and the RESYNC_LEN default constant.
- Sub-module count_chk_sat_cnt (parameter W; ports inc, clr, q; saturating, clr-priority), instantiated for err_count and for wrap_count.

Test Plan:
- Reset, then feed 5,6,7,8 with in_valid every cycle -> locked rises 1 cycle after sample 8 (RESYNC_LEN=3); expected=9; err_count=0.
- Locked, feed 14,15,0,1 -> no mismatch; wrap_count=1 with the feature defined.
- Locked at expected=4, feed 0 (counter reset) -> mismatch pulse 1 cycle; err_count=1; locked=0. Then 1,2,3 -> relock after 3.
- Force 256 locked-mismatch/relock cycles -> err_count saturates at 255. Assert clear in the same cycle as a mismatch -> err_count=0, mismatch still pulses.
- While acquiring (good_run=2), feed an out-of-sequence value -> no pulse, err_count unchanged, acquisition restarts and needs 3 more good samples. enable=0 for 10 cycles with random in_count -> all outputs hold.
- rst asserted while locked with err_count=7 -> next cycle all outputs are 0, state UNLOCKED.
